// File: rtl/mux_rr_arb.sv
// mux_rr_arb
//   N-channel, W-bit arbitrating multiplexer with a single registered output
//   stage. Each cycle the output stage can take a word, one requesting
//   channel is granted, either by round-robin starting at ptr or by fixed
//   priority (lowest index first). The granted word and its channel index
//   are registered and offered downstream with a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    [N]    per-channel request
//   in_data     [N*W]  channel k data in bits [k*W +: W]
//   in_ready    [N]    one-hot grant (or zero)
//   prio_fixed  1 = fixed priority, 0 = round-robin
//   out_valid   output register holds a word
//   out_data    [W]    registered word
//   out_ch      [CW]   channel that supplied out_data
//   out_ready   consumer accepts the word
//
// Output stage states
//   state    | meaning
//   ---------+--------------------------------------------
//   ST_EMPTY | no word held, out_valid = 0, may load
//   ST_FULL  | word held, out_valid = 1, may load only if
//            | the consumer takes the current word
module mux_rr_arb #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  input  logic            prio_fixed,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_ch,
  input  logic            out_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] ch_q, ch_d;

  logic          can_load;
  logic          grant_vld;
  logic [CW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic          load;

  // rst_n is folded in so that no grant is advertised while reset is held,
  // even though the stage is EMPTY during reset.
  assign can_load = rst_n & ((state_q == ST_EMPTY) | out_ready);

  // Arbitration. Round-robin is done as two linear passes: first the
  // channels at or above ptr, then the ones below it (the wrapped part).
  // In fixed mode the first pass covers every channel, lowest first, and
  // the second pass is disabled.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && in_valid[k] && (prio_fixed || (k >= int'(ptr_q)))) begin
        grant_vld = 1'b1;
        grant_idx = CW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && in_valid[k] && !prio_fixed && (k < int'(ptr_q))) begin
        grant_vld = 1'b1;
        grant_idx = CW'(k);
      end
    end
  end

  // Data select feeds only the output register, so in_data never reaches
  // an output combinationally.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == CW'(k)) begin
        grant_data = in_data[k*W +: W];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = can_load & grant_vld & (grant_idx == CW'(k));
    end
  end

  // A granted channel always has in_valid set, so a grant under can_load
  // is a transfer.
  assign load = can_load & grant_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (load) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    ptr_d  = ptr_q;
    if (load) begin
      data_d = grant_data;
      ch_d   = grant_idx;
      if (!prio_fixed) begin
        ptr_d = (grant_idx == CW'(N - 1)) ? '0 : CW'(grant_idx + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;

  logic clk;
  logic rst_n;

  // N=4, W=8
  logic [3:0]  iv;
  logic [31:0] id;
  logic [3:0]  ir;
  logic        pf;
  logic        ov;
  logic [7:0]  od;
  logic [1:0]  och;
  logic        ordy;

  // N=5, W=16
  logic [4:0]  iv5;
  logic [79:0] id5;
  logic [4:0]  ir5;
  logic        ov5;
  logic [15:0] od5;
  logic [2:0]  och5;

  // N=1, W=1
  logic [0:0]  iv1;
  logic [0:0]  id1;
  logic [0:0]  ir1;
  logic        ov1;
  logic [0:0]  od1;
  logic [0:0]  och1;
  logic        ordy1;

  int n_chk;
  int n_fail;

  mux_rr_arb #(.N(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(id), .in_ready(ir),
    .prio_fixed(pf), .out_valid(ov), .out_data(od), .out_ch(och), .out_ready(ordy)
  );

  mux_rr_arb #(.N(5), .W(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_data(id5), .in_ready(ir5),
    .prio_fixed(1'b0), .out_valid(ov5), .out_data(od5), .out_ch(och5), .out_ready(1'b1)
  );

  mux_rr_arb #(.N(1), .W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .prio_fixed(1'b0), .out_valid(ov1), .out_data(od1), .out_ch(och1), .out_ready(ordy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    iv     = 4'hF;
    id     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    pf     = 1'b0;
    ordy   = 1'b1;
    iv5    = '0;
    id5    = {16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000};
    iv1    = 1'b0;
    id1    = 1'b0;
    ordy1  = 1'b1;

    // reset state
    #12;
    chk("rst_ov",  32'(ov),  32'd0);
    chk("rst_od",  32'(od),  32'd0);
    chk("rst_och", 32'(och), 32'd0);
    chk("rst_ir",  32'(ir),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_ir", 32'(ir), 32'h1);

    // round-robin sweep
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_ov%0d", i),  32'(ov),  32'd1);
      chk($sformatf("rr_och%0d", i), 32'(och), 32'(i % 4));
      chk($sformatf("rr_od%0d", i),  32'(od),  32'(8'hA0 + (i % 4)));
      chk($sformatf("rr_ir%0d", i),  32'(ir),  32'(4'b0001 << ((i + 1) % 4)));
    end

    // asynchronous reset while FULL
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",  32'(ov),  32'd0);
    chk("mid_rst_od",  32'(od),  32'd0);
    chk("mid_rst_och", 32'(och), 32'd0);
    chk("mid_rst_ir",  32'(ir),  32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_och", 32'(och), 32'd0);
    chk("post_rst_od",  32'(od),  32'hA0);

    // move ptr to 2 via a round-robin grant on channel 1
    iv = 4'b0010;
    tick();
    chk("set_ptr_och", 32'(och), 32'd1);

    // fixed priority
    iv = 4'b1010;
    pf = 1'b1;
    #1;
    chk("fix_ir_pre", 32'(ir), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fix_och%0d", i), 32'(och), 32'd1);
      chk($sformatf("fix_od%0d", i),  32'(od),  32'hA1);
      chk($sformatf("fix_ir%0d", i),  32'(ir),  32'b0010);
    end
    pf = 1'b0;
    #1;
    chk("rr_after_fix_ir", 32'(ir), 32'b1000);
    tick();
    chk("rr_after_fix_och", 32'(och), 32'd3);
    chk("rr_after_fix_od",  32'(od),  32'hA3);

    // backpressure
    id[23:16] = 8'h55;
    iv = 4'b0100;
    tick();
    chk("bp_load_och", 32'(och), 32'd2);
    chk("bp_load_od",  32'(od),  32'h55);
    ordy = 1'b0;
    iv   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ir%0d", i), 32'(ir), 32'd0);
      tick();
      chk($sformatf("bp_ov%0d", i),  32'(ov),  32'd1);
      chk($sformatf("bp_od%0d", i),  32'(od),  32'h55);
      chk($sformatf("bp_och%0d", i), 32'(och), 32'd2);
    end
    ordy = 1'b1;
    #1;
    chk("bp_rel_ir", 32'(ir), 32'b1000);
    tick();
    chk("bp_rel_ov",  32'(ov),  32'd1);
    chk("bp_rel_och", 32'(och), 32'd3);
    chk("bp_rel_od",  32'(od),  32'hA3);
    id[23:16] = 8'hA2;

    // sparse traffic on channel 3
    for (int i = 0; i < 3; i++) begin
      iv = 4'b1000;
      #1;
      chk($sformatf("sp_ir%0d", i), 32'(ir), 32'b1000);
      tick();
      iv = 4'b0000;
      chk($sformatf("sp_ov%0d", i),  32'(ov),  32'd1);
      chk($sformatf("sp_och%0d", i), 32'(och), 32'd3);
      tick();
      chk($sformatf("sp_gap_a%0d", i), 32'(ov), 32'd0);
      chk($sformatf("sp_hold_od%0d", i), 32'(od), 32'hA3);
      tick();
      chk($sformatf("sp_gap_b%0d", i), 32'(ov), 32'd0);
    end
    iv = 4'hF;
    #1;
    chk("sp_ptr0_ir", 32'(ir), 32'b0001);
    iv = 4'h0;

    // N=5, W=16 sweep including wrap 4 -> 0
    iv5 = 5'h1F;
    #1;
    chk("n5_first_ir", 32'(ir5), 32'b00001);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("n5_ov%0d", i),  32'(ov5),  32'd1);
      chk($sformatf("n5_och%0d", i), 32'(och5), 32'(i % 5));
      chk($sformatf("n5_od%0d", i),  32'(od5),  32'(16'hB000 + (i % 5)));
      chk($sformatf("n5_range%0d", i), 32'(och5 < 3'd5), 32'd1);
    end
    iv5 = '0;

    // N=1, W=1 register slice
    iv1 = 1'b1;
    id1 = 1'b1;
    tick();
    chk("n1_ov_a",  32'(ov1),  32'd1);
    chk("n1_od_a",  32'(od1),  32'd1);
    chk("n1_och_a", 32'(och1), 32'd0);
    id1 = 1'b0;
    tick();
    chk("n1_od_b", 32'(od1), 32'd0);
    iv1 = 1'b0;
    tick();
    chk("n1_ov_c", 32'(ov1), 32'd0);
    iv1 = 1'b1;
    id1 = 1'b1;
    tick();
    ordy1 = 1'b0;
    id1   = 1'b0;
    #1;
    chk("n1_bp_ir", 32'(ir1), 32'd0);
    tick();
    chk("n1_bp_ov", 32'(ov1), 32'd1);
    chk("n1_bp_od", 32'(od1), 32'd1);
    ordy1 = 1'b1;
    #1;
    chk("n1_rel_ir", 32'(ir1), 32'd1);
    tick();
    chk("n1_rel_od", 32'(od1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised N-channel, W-bit arbitrating multiplexer: the sequential successor to the combinational 4:1 select mux. Instead of an external select, each input channel raises a valid/ready request. The block picks one requester per cycle, by round-robin or fixed priority, and registers the selected word and its channel index into a single output stage with a valid/ready handshake. It sits between multiple producers and one shared consumer (bus, FIFO, or serialiser).

## Interface
- `N`, default 4: number of input channels, N ≥ 1.
- `W`, default 8: data width per channel, W ≥ 1.
- `CW`, default `$clog2(N)` (forced to 1 when N = 1): channel-index width.

- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  N  per-channel request; bit k belongs to channel k.
- `in_data`  in  N*W  channel k occupies bits [k*W +: W].
- `in_ready`  out  N  one-hot or zero; the grant to channel k.
- `prio_fixed`  in  1  0 selects round-robin, 1 selects fixed priority (lowest index wins).
- `out_valid`  out  1  the output register holds a word.
- `out_data`  out  W  the registered selected word.
- `out_ch`  out  CW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  the consumer accepts the word.

## Operation
- Output stage has two states.
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `can_load` = EMPTY, or (FULL and `out_ready`).
- Arbitration is combinational each cycle and active only when `can_load`=1.
  - Round-robin: search from index `ptr`, upward with wrap at N−1 → 0. The first k with `in_valid[k]`=1 is granted.
  - Fixed priority: the lowest k with `in_valid[k]`=1 is granted. `ptr` is ignored.
- `in_ready[k]`=1 only for the granted k, and only when `can_load`=1. All other bits are 0. With no requester, `in_ready`=0.
- A transfer on channel k occurs when `in_valid[k]` and `in_ready[k]` are both 1. On the next edge:
  - `out_data` ← channel k data,
  - `out_ch` ← k,
  - state ← FULL,
  - in round-robin mode only, `ptr` ← (k+1) mod N.
- FULL with `out_ready`=1 and no transfer: state ← EMPTY. `out_data` and `out_ch` keep their last value.
- FULL with `out_ready`=1 and a transfer in the same cycle: stays FULL with the new word. No bubble.
- FULL with `out_ready`=0: `out_valid`, `out_data`, and `out_ch` stay stable. `in_ready` is all 0.
- `ptr` does not change in fixed mode or on cycles with no grant.
- `prio_fixed` may change on any cycle. It takes effect in the same cycle's arbitration and needs no drain.
- N=1: the block degenerates to a one-entry register slice. `out_ch` is always 0.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge):
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0, state EMPTY.
  - `in_ready`=0 while `rst_n`=0.
- Latency: a word accepted at edge t is visible on `out_*` after edge t.
- Throughput: one word per cycle while the consumer holds `out_ready`=1.
- Combinational paths:
  - `in_ready` depends on `in_valid`, `out_ready`, `prio_fixed`, state, and `ptr`.
  - No output depends combinationally on `in_data`.
- Reset mid-transfer: the held word is discarded. `out_valid` drops immediately, asynchronously. The first grant after release uses `ptr`=0.
- Producers must hold `in_valid` and data until granted. The block does not require this for correctness, but a withdrawn request is simply not granted.
- Round-robin fairness: with all N requesting continuously and `out_ready`=1, the grants are 0,1,…,N−1,0,… Each channel is served exactly once per N cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-run with FULL output. Required: `out_valid`, `out_data`, and `out_ch` go to 0 without waiting for a clock edge, and `in_ready`=0. After release, the first grant with all requesting is channel 0.
- Round-robin sweep: N=4, W=8, channel data 0xA0–0xA3, all `in_valid`=1, `out_ready`=1, `prio_fixed`=0. Required: `out_ch` sequence 0,1,2,3,0,1 on consecutive cycles, with `out_data` matching the channel.
- Fixed priority: `in_valid`=4'b1010 held, `prio_fixed`=1. Required: every grant is channel 1 and channel 3 never gets `in_ready`. Switching to `prio_fixed`=0 with `ptr`=2 gives a grant to channel 3 first.
- Backpressure: load 0x55 from channel 2, then hold `out_ready`=0 for 5 cycles with requests pending. Required: `out_valid`=1, `out_data`=0x55, `out_ch`=2 stable, and `in_ready`=0 throughout. On release, the next word loads in the same cycle that 0x55 is consumed.
- Sparse traffic: a single request on channel 3 every 3rd cycle. Required: 1-cycle latency, `out_valid` returns to 0 between words, and `ptr` holds 0 after each grant.
- Parameter corners: N=1, W=1 and N=5, W=16 (wrap 4 → 0). Required: same ordering and handshake rules hold, and `out_ch` is never ≥ N.
